// File: rtl/vc_credit_recv_queue_if.sv
// rtl/vc_credit_recv_queue_if.sv - credited upstream link plus val/rdy downstream link
interface vc_credit_recv_queue_if #(
  parameter int p_msg_nbits = 32
);
  logic                   in_val;
  logic [p_msg_nbits-1:0] in_msg;
  logic                   credit_ret;
  logic                   out_val;
  logic                   out_rdy;
  logic [p_msg_nbits-1:0] out_msg;

  modport master (
    output in_val, in_msg, out_rdy,
    input  credit_ret, out_val, out_msg
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output credit_ret, out_val, out_msg
  );
endinterface

// File: rtl/vc_credit_recv_queue.sv
// rtl/vc_credit_recv_queue.sv - credit-returning receive FIFO with initial credit grant
module vc_credit_recv_queue #(
  parameter int p_msg_nbits   = 32,
  parameter int p_num_entries = 4,
  parameter int p_cnt_nbits   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  vc_credit_recv_queue_if.slave  link,
  output logic [p_cnt_nbits-1:0] count,
  output logic                   init_done,
  output logic                   overflow
);
  localparam int p_ptr_nbits = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam logic [p_ptr_nbits-1:0] last_ptr   = p_ptr_nbits'(p_num_entries - 1);
  localparam logic [p_cnt_nbits-1:0] last_grant = p_cnt_nbits'(p_num_entries - 1);
  localparam logic [p_cnt_nbits-1:0] full_cnt   = p_cnt_nbits'(p_num_entries);

  typedef enum logic {st_init, st_run} state_t;

  state_t                 state, state_next;
  logic [p_cnt_nbits-1:0] grant_cnt, grant_cnt_next;
  logic                   credit_init;
  logic                   credit_run_q;
  logic [p_msg_nbits-1:0] mem [p_num_entries];
  logic [p_ptr_nbits-1:0] head, tail;
  logic                   full, fire, enq;

  function automatic logic [p_ptr_nbits-1:0] next_ptr(input logic [p_ptr_nbits-1:0] p);
    return (p == last_ptr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= st_init;
      grant_cnt <= '0;
    end else begin
      state     <= state_next;
      grant_cnt <= grant_cnt_next;
    end
  end

  // One credit per INIT cycle; leave INIT after the p_num_entries-th pulse.
  always_comb begin
    state_next     = state;
    grant_cnt_next = grant_cnt;
    credit_init    = 1'b0;
    case (state)
      st_init: begin
        credit_init    = 1'b1;
        grant_cnt_next = grant_cnt + 1'b1;
        if (grant_cnt == last_grant) state_next = st_run;
      end
      st_run: begin
        state_next = st_run;
      end
    endcase
  end

  assign init_done       = (state == st_run);
  assign full            = (count == full_cnt);
  assign link.out_val    = (count != '0) & init_done;
  assign link.out_msg    = mem[head];
  assign fire            = link.out_val & link.out_rdy;
  assign enq             = link.in_val & (~full | fire);
  // Reset gates the INIT credit so no pulse leaks while reset is held.
  assign link.credit_ret = (credit_init | credit_run_q) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      credit_run_q <= 1'b0;
    end else begin
      credit_run_q <= fire;
      if (enq)  tail <= next_ptr(tail);
      if (fire) head <= next_ptr(head);
      if (enq & ~fire)      count <= count + 1'b1;
      else if (fire & ~enq) count <= count - 1'b1;
      if (link.in_val & ~enq) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) mem[i] <= '0;
    end else if (enq) begin
      mem[tail] <= link.in_msg;
    end
  end
endmodule

// File: tb/tb_vc_credit_recv_queue.sv
// tb/tb_vc_credit_recv_queue.sv - scoreboard bench for vc_credit_recv_queue
module tb_vc_credit_recv_queue;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] count;
  logic          init_done;
  logic          overflow;

  vc_credit_recv_queue_if #(.p_msg_nbits(W)) link ();

  vc_credit_recv_queue #(
    .p_msg_nbits  (W),
    .p_num_entries(N),
    .p_cnt_nbits  (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .link     (link),
    .count    (count),
    .init_done(init_done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];
  int m_count  = 0;
  int m_grants = 0;
  bit m_ovf    = 1'b0;
  bit m_cred   = 1'b0;
  bit m_live   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, credits and errors from the link rules.
  initial begin
    bit fire, enq, done;
    forever begin
      @(posedge clk);
      done = (m_grants == N);
      fire = m_live && done && (m_count != 0) && (link.out_rdy === 1'b1);
      if (reset === 1'b1) begin
        exp_q.delete();
        m_count  = 0;
        m_grants = 0;
        m_ovf    = 1'b0;
        m_cred   = 1'b0;
        m_live   = 1'b1;
      end else if (m_live) begin
        enq = (link.in_val === 1'b1) && ((m_count < N) || fire);
        if (enq) exp_q.push_back(link.in_msg);
        else if (link.in_val === 1'b1) m_ovf = 1'b1;
        m_count = m_count + int'(enq) - int'(fire);
        m_cred  = fire;
        if (m_grants < N) m_grants++;
      end
    end
  end

  // Monitor: compares DUT outputs each cycle and pops the scoreboard on a dequeue.
  initial begin
    bit           exp_val;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (m_live && reset === 1'b0) begin
        exp_val = (m_count != 0) && (m_grants == N);
        chk("credit_ret", 64'(link.credit_ret), 64'((m_grants < N) || m_cred));
        chk("init_done", 64'(init_done), 64'(m_grants == N));
        chk("out_val", 64'(link.out_val), 64'(exp_val));
        chk("count", 64'(count), 64'(m_count));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (exp_val && link.out_rdy === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 64'(0), 64'(1));
          end else begin
            e = exp_q.pop_front();
            chk("out_msg", 64'(link.out_msg), 64'(e));
          end
        end
      end
    end
  end

  task automatic drive(input bit r, input bit v, input logic [W-1:0] m, input bit rdy);
    reset        = r;
    link.in_val  = v;
    link.in_msg  = m;
    link.out_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset then idle through INIT
    drive(1, 0, '0, 0);
    repeat (8) drive(0, 0, '0, 0);
    // back-to-back A,B,C with ready high
    drive(0, 1, 32'hA, 1);
    drive(0, 1, 32'hB, 1);
    drive(0, 1, 32'hC, 1);
    repeat (4) drive(0, 0, '0, 1);
    // fill, overflow on fifth, then drain
    for (int i = 0; i < 5; i++) drive(0, 1, 32'h100 + i, 0);
    repeat (6) drive(0, 0, '0, 1);
    // full with simultaneous enq/deq across pointer wrap
    drive(1, 0, '0, 0);
    repeat (4) drive(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h200 + i, 0);
    for (int i = 1; i <= 10; i++) drive(0, 1, i, 1);
    repeat (6) drive(0, 0, '0, 1);
    // enqueue during INIT after second credit
    drive(1, 0, '0, 0);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    drive(0, 1, 32'h55, 1);
    repeat (5) drive(0, 0, '0, 1);
    // reset with three buffered entries
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h300 + i, 0);
    drive(1, 0, '0, 1);
    repeat (6) drive(0, 0, '0, 1);
    // randomized traffic with occasional resets
    repeat (600) drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6,
                       $urandom, $urandom_range(0, 3) != 0);
    repeat (8) drive(0, 0, '0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
